// File: rtl/ext_pipe.sv
// ---------------------------------------------------------------------------
// ext_pipe
//
// Pipelined extension unit for the MIPS core. One block covers instruction
// immediates (zero-extend, sign-extend, lui placement) and sub-word load data
// (lb, lbu, lh, lhu, lw). The result is computed combinationally from the
// request, registered into stage 0, then carried unchanged through the rest
// of an elastic pipeline with valid/ready on both sides. Misaligned halfword
// and word loads flow through as errored results (data forced to zero), and
// a saturating counter tallies errored results as they are delivered.
//
// Parameters
//   IMM_W   immediate width taken from in_data[IMM_W-1:0] (1..31)
//   STAGES  number of register stages between input and output (1..4)
//   CNT_W   width of the saturating error counter
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   in_valid    request present
//   in_ready    request accepted this cycle when in_valid is also high
//   in_op       000 zext imm, 001 sext imm, 010 lui, 011 lb, 100 lbu,
//               101 lh, 110 lhu, 111 lw
//   in_data     immediate (low IMM_W bits) or raw little-endian memory word
//   in_addr_lo  byte offset of the load address (loads only)
//   flush       drop everything in flight; blocks input this cycle
//   out_valid   result present
//   out_ready   consumer takes the result this cycle
//   out_data    extended result (zero for misaligned requests)
//   out_err     result came from a misaligned access
//   err_cnt     number of errored results delivered, saturating
// ---------------------------------------------------------------------------
module ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_addr_lo,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    OP_ZEXT = 3'b000,
    OP_SEXT = 3'b001,
    OP_LUI  = 3'b010,
    OP_LB   = 3'b011,
    OP_LBU  = 3'b100,
    OP_LH   = 3'b101,
    OP_LHU  = 3'b110,
    OP_LW   = 3'b111
  } op_e;

  localparam int LAST = STAGES - 1;

  op_e              op;
  logic [IMM_W-1:0] imm;
  logic [7:0]       byteLane;
  logic [15:0]      halfLane;
  logic [31:0]      extData;
  logic             extErr;

  logic [STAGES-1:0] advance;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [31:0]       data_q [STAGES];
  logic [31:0]       data_d [STAGES];
  logic              err_q  [STAGES];
  logic              err_d  [STAGES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic outXfer;

  assign op  = op_e'(in_op);
  assign imm = in_data[IMM_W-1:0];

  // Lane selection for sub-word loads. Memory is little-endian, so the byte
  // offset picks the lane directly; halfwords only use bit 1 of the offset
  // because odd offsets are reported as misaligned anyway.
  always_comb begin
    byteLane = in_data[7:0];
    case (in_addr_lo)
      2'd0: byteLane = in_data[7:0];
      2'd1: byteLane = in_data[15:8];
      2'd2: byteLane = in_data[23:16];
      2'd3: byteLane = in_data[31:24];
      default: byteLane = in_data[7:0];
    endcase
    halfLane = in_addr_lo[1] ? in_data[31:16] : in_data[15:0];
  end

  // Combinational extension of the incoming request. A misaligned access
  // produces zero data with the error flag set so the consumer never sees a
  // half-formed value.
  always_comb begin
    extData = '0;
    extErr  = 1'b0;
    case (op)
      OP_ZEXT: extData = {{(32-IMM_W){1'b0}}, imm};
      OP_SEXT: extData = {{(32-IMM_W){imm[IMM_W-1]}}, imm};
      OP_LUI:  extData = {imm, {(32-IMM_W){1'b0}}};
      OP_LB:   extData = {{24{byteLane[7]}}, byteLane};
      OP_LBU:  extData = {24'd0, byteLane};
      OP_LH: begin
        if (in_addr_lo[0]) extErr = 1'b1;
        else               extData = {{16{halfLane[15]}}, halfLane};
      end
      OP_LHU: begin
        if (in_addr_lo[0]) extErr = 1'b1;
        else               extData = {16'd0, halfLane};
      end
      OP_LW: begin
        if (in_addr_lo != 2'b00) extErr = 1'b1;
        else                     extData = in_data;
      end
      default: begin
        extData = '0;
        extErr  = 1'b0;
      end
    endcase
  end

  // A stage may take new contents when it is empty or when everything
  // downstream of it moves. Expanded as "out_ready or any stage from here to
  // the output is empty" so there is no self-referencing chain through the
  // advance vector.
  always_comb begin
    logic any;
    advance = '0;
    for (int i = 0; i < STAGES; i++) begin
      any = out_ready;
      for (int j = i; j < STAGES; j++) begin
        if (!valid_q[j]) any = 1'b1;
      end
      advance[i] = any;
    end
  end

  // in_ready depends only on registered state, out_ready and flush, so no
  // combinational path exists from in_valid or in_data to any output.
  assign in_ready = !flush && advance[0];
  assign outXfer  = valid_q[LAST] && out_ready;

  // Next-state for the pipeline stages. Stage 0 captures the extension result
  // on an input transfer; later stages copy their predecessor whenever they
  // advance. A flush empties every stage but leaves data registers alone,
  // since payload without a valid is never observed.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;

    if (advance[0]) begin
      valid_d[0] = in_valid && in_ready;
      data_d[0]  = extData;
      err_d[0]   = extErr;
    end

    for (int i = 1; i < STAGES; i++) begin
      if (advance[i]) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
        err_d[i]   = err_q[i-1];
      end
    end

    if (flush) valid_d = '0;
  end

  // Error counter counts delivered errored results only, including a
  // delivery that coincides with a flush, and sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (outXfer && err_q[LAST] && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers. Reset drops every in-flight result and clears the
  // visible outputs, including the payload of the last stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
        err_q[i]  <= 1'b0;
      end
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= data_d[i];
        err_q[i]  <= err_d[i];
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign out_data  = data_q[LAST];
  assign out_err   = err_q[LAST];
  assign err_cnt   = cnt_q;

endmodule
